// File: rtl/intlv_wr_ctrl.sv
// Interleaver write-side controller.
// Accepts a frame of FRAME_LEN samples, walks the permutation ROM with a
// sequential index and writes each sample to the buffer at the permuted
// address one cycle after it is accepted.
module intlv_wr_ctrl #(
  parameter int D_WIDTH   = 8,
  parameter int A_WIDTH   = 10,
  parameter int FRAME_LEN = 2**A_WIDTH
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               mode_in,
  input  logic               abort,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               in_ready,
  output logic [A_WIDTH-1:0] rom_raddr,
  output logic               rom_mode,
  input  logic [A_WIDTH-1:0] rom_data,
  output logic               mem_we,
  output logic [A_WIDTH-1:0] mem_waddr,
  output logic [D_WIDTH-1:0] mem_wdata,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [A_WIDTH-1:0] LAST_IDX = A_WIDTH'(FRAME_LEN - 1);
  localparam logic [A_WIDTH-1:0] ONE      = A_WIDTH'(1);
  localparam logic [A_WIDTH-1:0] ZERO     = A_WIDTH'(0);

  state_t             state;
  state_t             state_nxt;
  logic [A_WIDTH-1:0] count;
  logic               accept;
  logic               last_accept;
  logic               frame_start;

  // Status outputs are plain decodes of the state register.
  assign in_ready    = (state == RUN);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign rom_raddr   = count;
  assign accept      = in_valid & in_ready;
  assign last_accept = accept & (count == LAST_IDX);
  assign frame_start = (state == IDLE) & start & ~abort;

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort wins over start and accept in every state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (last_accept) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Sample index: cleared on abort or frame start, wraps to 0 after the last sample.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= ZERO;
    end else if (abort || frame_start) begin
      count <= ZERO;
    end else if (last_accept) begin
      count <= ZERO;
    end else if (accept) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

  // ROM table select is captured only when a frame is accepted.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rom_mode <= 1'b0;
    end else if (frame_start) begin
      rom_mode <= mode_in;
    end else begin
      rom_mode <= rom_mode;
    end
  end

  // Buffer write port: one-cycle latency, address/data hold when no write.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_we    <= 1'b0;
      mem_waddr <= ZERO;
      mem_wdata <= {D_WIDTH{1'b0}};
    end else if (accept && !abort) begin
      mem_we    <= 1'b1;
      mem_waddr <= rom_data;
      mem_wdata <= in_data;
    end else begin
      mem_we    <= 1'b0;
      mem_waddr <= mem_waddr;
      mem_wdata <= mem_wdata;
    end
  end

endmodule
